// File: rtl/burst_acc_pkg.sv
// Width, state encoding and saturation limits shared by the burst accumulator files.
package burst_acc_pkg;

  localparam int W = 5;

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    DONE
  } state_t;

  localparam logic [W-1:0] SAT_POS = 5'b01111;
  localparam logic [W-1:0] SAT_NEG = 5'b10000;

endpackage

// File: rtl/burst_accumulator_if.sv
// Operand-in / result-out valid-ready bundle; slave is the accumulator, master the neighbour.
interface burst_accumulator_if;
  import burst_acc_pkg::*;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         in_op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_ov;

  modport master (
    output in_valid, in_data, in_op, out_ready,
    input  in_ready, out_valid, out_sum, out_ov
  );

  modport slave (
    input  in_valid, in_data, in_op, out_ready,
    output in_ready, out_valid, out_sum, out_ov
  );

endinterface

// File: rtl/burst_accumulator_adder.sv
// W-bit two's-complement ripple add/subtract (addsub=1 gives a-b); purely combinational.
// Latency: none; no handshake, so no backpressure.
module ripple_adder
  import burst_acc_pkg::*;
(
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         addsub_i,
  output logic [W-1:0] s_o,
  output logic         cout_o
);

  logic [W-1:0] b_eff;

  assign b_eff = b_i ^ {W{addsub_i}};

  always_comb begin : p_chain
    logic c;
    c   = addsub_i;
    s_o = '0;
    for (int i = 0; i < W; i++) begin
      s_o[i] = a_i[i] ^ b_eff[i] ^ c;
      c      = (a_i[i] & b_eff[i]) | (c & (a_i[i] ^ b_eff[i]));
    end
    cout_o = c;
  end

endmodule

// File: rtl/burst_accumulator.sv
// Folds LEN signed add/sub operands into a 5-bit sum with sticky overflow; result valid the cycle after the LEN-th accept.
// in_ready drops while the result waits for out_ready; BURST_ACC_SAT_EN selects saturating instead of wrapping steps.
module burst_accumulator
  import burst_acc_pkg::*;
#(
  parameter int LEN = 4
)
(
  input  logic                clk,
  input  logic                rst,
  burst_accumulator_if.slave  bus
);

  localparam logic [3:0] LEN_C = 4'(LEN);

  state_t       state_q, state_d;
  logic [W-1:0] acc_q, acc_d;
  logic         ov_q, ov_d;
  logic [3:0]   cnt_q, cnt_d;

  logic [W-1:0] add_a;
  logic [W-1:0] add_s;
  logic [W-1:0] step_val;
  logic         add_cout_unused;
  logic         eff_sign;
  logic         ovf_step;
  logic         accept;
  logic [3:0]   cnt_inc;

  assign add_a = (state_q == IDLE) ? '0 : acc_q;

  ripple_adder u_adder (
    .a_i      (add_a),
    .b_i      (bus.in_data),
    .addsub_i (bus.in_op),
    .s_o      (add_s),
    .cout_o   (add_cout_unused)
  );

  // Sign-based overflow also catches 0 - (-16), which the adder carry flag misreports.
  assign eff_sign = bus.in_data[W-1] ^ bus.in_op;
  assign ovf_step = (add_a[W-1] == eff_sign) && (add_s[W-1] != add_a[W-1]);

`ifdef BURST_ACC_SAT_EN
  assign step_val = ovf_step ? (add_a[W-1] ? SAT_NEG : SAT_POS) : add_s;
`else
  assign step_val = add_s;
`endif

  assign cnt_inc = cnt_q + 4'd1;
  assign accept  = bus.in_valid && bus.in_ready;

  assign bus.in_ready  = (state_q != DONE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_sum   = acc_q;
  assign bus.out_ov    = ov_q;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ov_d    = ov_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          acc_d   = step_val;
          ov_d    = ovf_step;
          cnt_d   = 4'd1;
          state_d = (LEN_C == 4'd1) ? DONE : ACC;
        end
      end
      ACC: begin
        if (accept) begin
          acc_d = step_val;
          ov_d  = ov_q | ovf_step;
          cnt_d = cnt_inc;
          if (cnt_inc == LEN_C) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
          acc_d   = '0;
          ov_d    = 1'b0;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        acc_d   = '0;
        ov_d    = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      ov_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ov_q    <= ov_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_burst_accumulator.sv
// Drives LEN=4, 3 and 1 accumulators from shared inputs; an integer model tracks each one.
module tb_burst_accumulator;
  import burst_acc_pkg::*;

`ifdef BURST_ACC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  localparam int N = 3;

  logic         clk       = 1'b0;
  logic         rst       = 1'b1;
  logic         in_valid  = 1'b0;
  logic         in_op     = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] in_data   = '0;

  logic [N-1:0] rdy_w, vld_w, ov_w;
  logic [W-1:0] sum_w [N];

  int m_acc  [N];
  bit m_ov   [N];
  int m_cnt  [N];
  bit m_done [N];

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  function automatic int len_of(input int g);
    return (g == 0) ? 4 : ((g == 1) ? 3 : 1);
  endfunction

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int L = (g == 0) ? 4 : ((g == 1) ? 3 : 1);
    burst_accumulator_if bus ();
    assign bus.in_valid  = in_valid;
    assign bus.in_data   = in_data;
    assign bus.in_op     = in_op;
    assign bus.out_ready = out_ready;
    assign rdy_w[g]      = bus.in_ready;
    assign vld_w[g]      = bus.out_valid;
    assign ov_w[g]       = bus.out_ov;
    assign sum_w[g]      = bus.out_sum;
    burst_accumulator #(.LEN(L)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );
  end

  // Model: exact integer arithmetic, then either clamp or wrap into -16..15.
  function automatic int raw_sum(input int acc, input logic op, input logic [W-1:0] d);
    int dv = int'($signed(d));
    return op ? acc - dv : acc + dv;
  endfunction

  function automatic bit out_of_range(input int v);
    return (v > 15) || (v < -16);
  endfunction

  function automatic int fold(input int v);
    if (!out_of_range(v)) return v;
    if (SAT) return (v > 15) ? 15 : -16;
    return (v > 15) ? v - 32 : v + 32;
  endfunction

  always @(posedge clk or posedge rst) begin
    for (int g = 0; g < N; g++) begin
      if (rst) begin
        m_acc[g]  <= 0;
        m_ov[g]   <= 1'b0;
        m_cnt[g]  <= 0;
        m_done[g] <= 1'b0;
      end else if (m_done[g]) begin
        if (out_ready) begin
          m_acc[g]  <= 0;
          m_ov[g]   <= 1'b0;
          m_cnt[g]  <= 0;
          m_done[g] <= 1'b0;
        end
      end else if (in_valid) begin
        m_acc[g] <= fold(raw_sum(m_acc[g], in_op, in_data));
        m_ov[g]  <= m_ov[g] | out_of_range(raw_sum(m_acc[g], in_op, in_data));
        m_cnt[g] <= m_cnt[g] + 1;
        if (m_cnt[g] + 1 == len_of(g)) m_done[g] <= 1'b1;
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  always @(negedge clk) begin
    for (int g = 0; g < N; g++) begin
      chk($sformatf("model_in_ready[%0d]", g), int'(rdy_w[g]), int'(!m_done[g]));
      chk($sformatf("model_out_valid[%0d]", g), int'(vld_w[g]), int'(m_done[g]));
      if (m_done[g]) begin
        chk($sformatf("model_out_sum[%0d]", g), int'($signed(sum_w[g])), m_acc[g]);
        chk($sformatf("model_out_ov[%0d]", g), int'(ov_w[g]), int'(m_ov[g]));
      end
    end
  end

  // Called at a falling edge; returns at the falling edge after the accepting rising edge.
  task automatic send(input int g, input logic op, input logic [W-1:0] d);
    int  n    = 0;
    bit  took = 1'b0;
    in_valid = 1'b1;
    in_op    = op;
    in_data  = d;
    while (!took && n < 20) begin
      took = rdy_w[g];
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    in_valid = 1'b0;
    if (!took) chk("send_timeout", 0, 1);
  endtask

  task automatic take(input int g);
    int n = 0;
    while (!vld_w[g] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("take_wait_valid", int'(vld_w[g]), 1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic idle(input int cycles);
    in_valid = 1'b0;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset_out_valid", int'(vld_w[0]), 0);
    chk("reset_in_ready", int'(rdy_w[0]), 1);
    chk("reset_out_sum", int'(sum_w[0]), 0);
    chk("reset_out_ov", int'(ov_w[0]), 0);

    // 3+4+5+2, back-to-back
    send(0, 1'b0, 5'd3);
    send(0, 1'b0, 5'd4);
    send(0, 1'b0, 5'd5);
    send(0, 1'b0, 5'd2);
    chk("t1_valid_next_cycle", int'(vld_w[0]), 1);
    chk("t1_sum", int'(sum_w[0]), 14);
    chk("t1_ov", int'(ov_w[0]), 0);

    // Result held under backpressure while operands are offered
    in_valid = 1'b1;
    in_op    = 1'b0;
    in_data  = 5'd1;
    repeat (5) begin
      @(negedge clk);
      chk("bp_sum_stable", int'(sum_w[0]), 14);
      chk("bp_in_ready", int'(rdy_w[0]), 0);
      chk("bp_out_valid", int'(vld_w[0]), 1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk("release_out_valid", int'(vld_w[0]), 0);
    chk("release_in_ready", int'(rdy_w[0]), 1);

    // 7+7+3-1 overflows mid-burst
    send(0, 1'b0, 5'd7);
    send(0, 1'b0, 5'd7);
    send(0, 1'b0, 5'd3);
    send(0, 1'b1, 5'd1);
    chk("t2_sum", int'(sum_w[0]), SAT ? 14 : 16);
    chk("t2_ov", int'(ov_w[0]), 1);
    take(0);

    // 0 - (-16) then +0 x3
    send(0, 1'b1, 5'b10000);
    repeat (3) send(0, 1'b0, 5'd0);
    chk("t3_sum", int'(sum_w[0]), SAT ? 15 : 16);
    chk("t3_ov", int'(ov_w[0]), 1);
    take(0);

    // LEN=3 with idle gaps between operands
    do_reset();
    send(1, 1'b0, 5'd1);
    idle(2);
    send(1, 1'b0, 5'd2);
    idle(2);
    chk("gap_not_done_early", int'(vld_w[1]), 0);
    send(1, 1'b0, 5'd3);
    chk("gap_valid", int'(vld_w[1]), 1);
    chk("gap_sum", int'(sum_w[1]), 6);
    chk("gap_ov", int'(ov_w[1]), 0);
    take(1);

    // LEN=1 single-operand bursts
    do_reset();
    send(2, 1'b0, 5'b11101);
    chk("len1_valid", int'(vld_w[2]), 1);
    chk("len1_sum", int'(sum_w[2]), 29);
    chk("len1_ov", int'(ov_w[2]), 0);
    take(2);
    send(2, 1'b1, 5'b10000);
    chk("len1_neg16_sum", int'(sum_w[2]), SAT ? 15 : 16);
    chk("len1_neg16_ov", int'(ov_w[2]), 1);
    take(2);

    // Reset in the middle of a burst
    do_reset();
    send(0, 1'b0, 5'd1);
    send(0, 1'b0, 5'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_out_valid", int'(vld_w[0]), 0);
    chk("midrst_acc", int'(sum_w[0]), 0);
    rst = 1'b0;
    repeat (4) send(0, 1'b0, 5'd1);
    chk("fresh_sum", int'(sum_w[0]), 4);
    chk("fresh_ov", int'(ov_w[0]), 0);
    take(0);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_chk);
    $fatal(1);
  end

endmodule
